// File: rtl/raw_stream_packer.sv
// raw_stream_packer: RGGB RAW bus to AXI4-Stream packer with overflow-flagging FIFO.
// Define RAW_PACKER_STATS_EN to add LINE_CNT/BEAT_CNT/LAST_LINE_BEATS counters.
module raw_stream_packer #(
  parameter int C_PORT_NUM        = 4,
  parameter int C_BITS_PER_CPNT   = 14,
  parameter int C_CPNTS_PER_PIXEL = 3,
  parameter int C_OUT_BITS        = 12,
  parameter int C_FIFO_DEPTH      = 16
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  S_VS,
  input  logic                                                  S_HS,
  input  logic                                                  S_DE,
  input  logic [C_BITS_PER_CPNT*C_CPNTS_PER_PIXEL*C_PORT_NUM-1:0] S_DATA,
  output logic [C_OUT_BITS*C_PORT_NUM-1:0]                      M_TDATA,
  output logic                                                  M_TVALID,
  input  logic                                                  M_TREADY,
  output logic                                                  M_TUSER,
  output logic                                                  M_TLAST,
  output logic                                                  OVERFLOW,
  output logic                                                  FRAME_DONE
`ifdef RAW_PACKER_STATS_EN
  ,
  output logic [15:0]                                           LINE_CNT,
  output logic [15:0]                                           BEAT_CNT,
  output logic [15:0]                                           LAST_LINE_BEATS
`endif
);
  localparam int BIT_NUM = C_BITS_PER_CPNT * C_CPNTS_PER_PIXEL;
  localparam int OW      = C_OUT_BITS * C_PORT_NUM;
  localparam int AW      = $clog2(C_FIFO_DEPTH);
  typedef enum logic [1:0] {WAIT_VS, ACTIVE, DROP} state_t;
  state_t state_q, state_d;
  logic vs_q, de_q, vs_pos, vs_neg;
  logic sof_pend_q, sof_pend_d, hold_vld_q, hold_vld_d, hold_sof_q, hold_sof_d;
  logic [OW-1:0] hold_data_q, hold_data_d, sample, out_data;
  logic ovf_q, ovf_d, wr_req, wr_last, wr_ok, wr_en, rd, rd_last, tag;
  logic out_sof, out_last, full, last_vld_q, frame_done_q;
  logic [OW+1:0] mem_q [C_FIFO_DEPTH];
  logic [C_FIFO_DEPTH-1:0] eof_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, last_ptr_q;
  logic [AW:0] cnt_q;
  logic unused_bits;
  assign unused_bits = ^{S_HS, S_DATA};
  for (genvar i = 0; i < C_PORT_NUM; i++) begin : g_ext
    assign sample[C_OUT_BITS*i +: C_OUT_BITS] = S_DATA[BIT_NUM*i + C_BITS_PER_CPNT-1 -: C_OUT_BITS];
  end
  assign vs_pos  = S_VS & ~vs_q;
  assign vs_neg  = ~S_VS & vs_q;
  assign full    = cnt_q == (AW+1)'(C_FIFO_DEPTH);
  assign rd      = M_TVALID & M_TREADY;
  assign wr_ok   = ~full | rd;
  assign wr_en   = wr_req & wr_ok;
  assign rd_last = rd & (rd_ptr_q == last_ptr_q);
  assign tag     = vs_neg & last_vld_q;
  always_comb begin
    state_d     = state_q;
    sof_pend_d  = sof_pend_q;
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    hold_sof_d  = hold_sof_q;
    ovf_d       = ovf_q;
    wr_req      = 1'b0;
    wr_last     = 1'b0;
    if (state_q == ACTIVE && S_DE) begin
      wr_req      = hold_vld_q;
      hold_vld_d  = 1'b1;
      hold_data_d = sample;
      hold_sof_d  = sof_pend_q;
      sof_pend_d  = 1'b0;
    end else if (state_q == ACTIVE && de_q && hold_vld_q) begin
      wr_req     = 1'b1;
      wr_last    = 1'b1;
      hold_vld_d = 1'b0;
    end
    if (vs_pos) begin
      state_d    = ACTIVE;
      sof_pend_d = 1'b1;
      ovf_d      = 1'b0;
    end
    if (wr_req && !wr_ok) begin
      state_d    = DROP;
      ovf_d      = 1'b1;
      hold_vld_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_VS;
      vs_q         <= 1'b0;
      de_q         <= 1'b0;
      sof_pend_q   <= 1'b0;
      hold_vld_q   <= 1'b0;
      hold_sof_q   <= 1'b0;
      hold_data_q  <= '0;
      ovf_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      last_ptr_q   <= '0;
      last_vld_q   <= 1'b0;
      eof_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vs_q         <= S_VS;
      de_q         <= S_DE;
      sof_pend_q   <= sof_pend_d;
      hold_vld_q   <= hold_vld_d;
      hold_sof_q   <= hold_sof_d;
      hold_data_q  <= hold_data_d;
      ovf_q        <= ovf_d;
      wr_ptr_q     <= wr_ptr_q + AW'(wr_en);
      rd_ptr_q     <= rd_ptr_q + AW'(rd);
      cnt_q        <= cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd);
      last_ptr_q   <= (wr_en && wr_last) ? wr_ptr_q : last_ptr_q;
      last_vld_q   <= (wr_en & wr_last) | (last_vld_q & ~rd_last);
      // a tagged beat leaving in the very cycle VS falls still counts as frame end
      frame_done_q <= rd & (eof_q[rd_ptr_q] | (tag & (rd_ptr_q == last_ptr_q)));
      if (wr_en) eof_q[wr_ptr_q] <= 1'b0;
      if (tag && !rd_last) eof_q[last_ptr_q] <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {wr_last, hold_sof_q, hold_data_q};
  end
  assign {out_last, out_sof, out_data} = mem_q[rd_ptr_q];
  assign M_TVALID   = cnt_q != '0;
  assign M_TDATA    = M_TVALID ? out_data : '0;
  assign M_TUSER    = M_TVALID & out_sof;
  assign M_TLAST    = M_TVALID & out_last;
  assign OVERFLOW   = ovf_q;
  assign FRAME_DONE = frame_done_q;
`ifdef RAW_PACKER_STATS_EN
  logic [15:0] line_q, beat_q, last_beats_q;
  always_ff @(posedge clk) begin
    if (rst || vs_pos) begin
      line_q       <= '0;
      beat_q       <= '0;
      last_beats_q <= '0;
    end else if (rd) begin
      line_q       <= (M_TLAST && line_q != 16'hFFFF) ? line_q + 16'd1 : line_q;
      beat_q       <= M_TLAST ? 16'd0 : (beat_q == 16'hFFFF ? beat_q : beat_q + 16'd1);
      last_beats_q <= M_TLAST ? (beat_q == 16'hFFFF ? beat_q : beat_q + 16'd1) : last_beats_q;
    end
  end
  assign LINE_CNT        = line_q;
  assign BEAT_CNT        = beat_q;
  assign LAST_LINE_BEATS = last_beats_q;
`endif
endmodule
